sdc_cmd_tx: RTL and testbench



---
 rtl/sdc_pkg.sv | 20 ++
 rtl/sdc_cmd_crc7.sv | 26 ++
 rtl/sdc_cmd_tx.sv | 135 +++++++++++++
 tb/tb_sdc_cmd_tx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdc_pkg.sv
// Shared constants and state encoding for the SD command transmitter.
// SDC_CMD_NCC_EN adds the NCC state used for the idle-high tail.
package sdc_pkg;

  localparam int SDC_CMD_FRAME_BITS   = 48;
  localparam int SDC_CMD_PAYLOAD_BITS = 40;
  localparam logic [6:0] SDC_CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
`ifdef SDC_CMD_NCC_EN
    S_SEND,
    S_NCC
`else
    S_SEND
`endif
  } sdc_cmd_state_e;

endpackage

// File: rtl/sdc_cmd_crc7.sv
// Serial CRC7 (x^7+x^3+1) with synchronous clear and bit enable.
// Unaffected by SDC_CMD_NCC_EN.
module sdc_cmd_crc7
  import sdc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       din,
  input  logic       clr,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  // Shift one message bit into the remainder per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst || clr)
      crc <= 7'h00;
    else if (ce)
      crc <= {crc[5:0], 1'b0} ^ (fb ? SDC_CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/sdc_cmd_tx.sv
// SD CMD-line transmitter: start, dir, index, arg, CRC7, end bit.
// Define SDC_CMD_NCC_EN to drive NCC_BITS idle-high bits afterwards.
module sdc_cmd_tx
  import sdc_pkg::*;
#(
  parameter int FRAME_BITS = SDC_CMD_FRAME_BITS,
  parameter int NCC_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_ce,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_o,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done
);

`ifdef SDC_CMD_NCC_EN
  localparam int TAIL = 1;
`else
  localparam int TAIL = 0;
`endif

  localparam logic [7:0] PAY_END = 8'(SDC_CMD_PAYLOAD_BITS);
  localparam logic [7:0] LAST    = 8'(FRAME_BITS + TAIL * NCC_BITS);
`ifdef SDC_CMD_NCC_EN
  localparam logic [7:0] FRM_END = 8'(FRAME_BITS);
`endif

  sdc_cmd_state_e state;
  logic [39:0]    shreg;
  logic [7:0]     bcnt;
  logic [6:0]     crc;
  logic           crc_ce;
  logic           crc_clr;

  assign crc_clr = cmd_valid && cmd_ready;
  assign crc_ce  = sd_ce &&
                   ((state == S_WAIT) ||
                    ((state == S_SEND) && (bcnt < PAY_END)));

  sdc_cmd_crc7 u_crc (
    .clk (clk),
    .rst (rst),
    .ce  (crc_ce),
    .din (shreg[39]),
    .clr (crc_clr),
    .crc (crc)
  );

  // Frame sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bcnt      <= '0;
      cmd_o     <= 1'b1;
      cmd_oe    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            shreg     <= {2'b01, cmd_index, cmd_arg};
            state     <= S_WAIT;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_WAIT: begin
          if (sd_ce) begin
            cmd_oe <= 1'b1;
            cmd_o  <= shreg[39];
            shreg  <= {shreg[38:0], 1'b0};
            bcnt   <= 8'd1;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (sd_ce) begin
            if (bcnt == LAST) begin
              cmd_o     <= 1'b1;
              cmd_oe    <= 1'b0;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              bcnt      <= '0;
              state     <= S_IDLE;
`ifdef SDC_CMD_NCC_EN
            end else if (bcnt == FRM_END) begin
              cmd_o <= 1'b1;
              bcnt  <= bcnt + 8'd1;
              state <= S_NCC;
`endif
            end else if (bcnt == PAY_END) begin
              // Reload with CRC[5:0] and the end bit behind it.
              cmd_o <= crc[6];
              shreg <= {crc[5:0], 1'b1, 33'd0};
              bcnt  <= bcnt + 8'd1;
            end else begin
              cmd_o <= shreg[39];
              shreg <= {shreg[38:0], 1'b0};
              bcnt  <= bcnt + 8'd1;
            end
          end
        end
`ifdef SDC_CMD_NCC_EN
        S_NCC: begin
          if (sd_ce) begin
            if (bcnt == LAST) begin
              cmd_oe    <= 1'b0;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              bcnt      <= '0;
              state     <= S_IDLE;
            end else begin
              bcnt <= bcnt + 8'd1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_cmd_tx.sv
// Self-checking bench for sdc_cmd_tx against a polynomial-division model.
// Honors SDC_CMD_NCC_EN for the expected tail length.
module tb_sdc_cmd_tx;

`ifdef SDC_CMD_NCC_EN
  localparam int TAIL = 8;
`else
  localparam int TAIL = 0;
`endif
  localparam int NB = 48 + TAIL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sd_ce = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_o;
  logic        cmd_oe;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int ce_mode = 0;

  logic q_bits[$];
  int   start_cyc[$];
  int   done_cyc[$];
  int   done_cnt = 0;
  int   done_tick = -1;
  int   chg_bad = 0;
  int   hs_bad = 0;
  int   cyc = 0;

  sdc_cmd_tx dut (
    .clk       (clk),
    .rst       (rst),
    .sd_ce     (sd_ce),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .cmd_o     (cmd_o),
    .cmd_oe    (cmd_oe),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // sd_ce generator: 0 = every 4th clk, 1 = always, 2 = random gaps.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      case (ce_mode)
        0: begin
          sd_ce = (cnt == 0);
          cnt = (cnt + 1) % 4;
        end
        1: sd_ce = 1'b1;
        default: begin
          if (cnt <= 0) begin
            sd_ce = 1'b1;
            cnt = $urandom_range(20, 0);
          end else begin
            sd_ce = 1'b0;
            cnt = cnt - 1;
          end
        end
      endcase
    end
  end

  // Line monitor: captures driven bits and protocol events.
  initial begin
    logic ce_was, rst_was, prev_o, prev_oe;
    prev_o = 1'b1;
    prev_oe = 1'b0;
    forever begin
      @(posedge clk);
      ce_was = sd_ce;
      rst_was = rst;
      #1;
      cyc++;
      if (!rst_was) begin
        if (ce_was && cmd_oe) q_bits.push_back(cmd_o);
        if (!ce_was && (cmd_o !== prev_o)) chg_bad++;
        if (cmd_oe && (cmd_ready || !busy)) hs_bad++;
        if (done) begin
          done_cnt++;
          done_tick = q_bits.size();
          done_cyc.push_back(cyc);
        end
        if (cmd_oe && !prev_oe) start_cyc.push_back(cyc);
      end
      prev_o = cmd_o;
      prev_oe = cmd_oe;
    end
  end

  function automatic logic [6:0] crc7_ref(input logic [39:0] p);
    logic [46:0] m;
    m = {p, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m = m ^ (47'h89 << (i - 7));
    return m[6:0];
  endfunction

  function automatic logic [47:0] frame_ref(input logic [5:0] idx,
                                            input logic [31:0] arg);
    logic [39:0] p;
    p = {2'b01, idx, arg};
    return {p, crc7_ref(p), 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    q_bits.delete();
    start_cyc.delete();
    done_cyc.delete();
    done_cnt = 0;
    done_tick = -1;
    chg_bad = 0;
    hs_bad = 0;
  endtask

  function automatic logic [47:0] get_frame(input int off);
    logic [47:0] f;
    f = 'x;
    if (q_bits.size() >= off + 48)
      for (int i = 0; i < 48; i++) f[47 - i] = q_bits[off + i];
    return f;
  endfunction

  function automatic int tail_ones(input int off);
    int n;
    n = 0;
    for (int i = 0; i < TAIL; i++)
      if (off + 48 + i < q_bits.size() && q_bits[off + 48 + i] === 1'b1)
        n++;
    return n;
  endfunction

  task automatic handshake(input logic [5:0] idx, input logic [31:0] arg);
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) chg_bad += 1000;
    cmd_index = idx;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_index = 6'($urandom);
    cmd_arg = $urandom;
  endtask

  task automatic wait_done(input string tag, input int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 64'(k >= 5000), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [5:0] idx,
                           input logic [31:0] arg,
                           input logic [47:0] exp);
    mon_clear();
    handshake(idx, arg);
    wait_done(tag, 1);
    chk({tag, "_frame"}, 64'(get_frame(0)), 64'(exp));
    chk({tag, "_nbits"}, 64'(q_bits.size()), 64'(NB));
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_tick"}, 64'(done_tick), 64'(NB));
    chk({tag, "_tail"}, 64'(tail_ones(0)), 64'(TAIL));
    chk({tag, "_hold"}, 64'(chg_bad), 64'd0);
    chk({tag, "_busy"}, 64'(hs_bad), 64'd0);
  endtask

  initial begin
    logic [5:0]  ia, ib;
    logic [31:0] aa, ab;
    logic [47:0] f;
    int k;

    repeat (3) @(negedge clk);
    chk("rst_cmd_o", 64'(cmd_o), 64'd1);
    chk("rst_cmd_oe", 64'(cmd_oe), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    ce_mode = 0;
    run_frame("cmd0", 6'd0, 32'h0, 48'h40_00_00_00_00_95);
    f = get_frame(0);
    chk("cmd0_crc", 64'(f[7:1]), 64'h4A);
    run_frame("cmd8", 6'd8, 32'h0000_01AA, 48'h48_00_00_01_AA_87);
    run_frame("cmd17", 6'd17, 32'h0, 48'h51_00_00_00_00_55);

    ce_mode = 2;
    for (int i = 0; i < 3; i++) begin
      ia = 6'($urandom_range(63, 0));
      aa = $urandom;
      run_frame("gap", ia, aa, frame_ref(ia, aa));
    end

    ce_mode = 1;
    ia = 6'($urandom_range(63, 0));
    aa = $urandom;
    ib = 6'($urandom_range(63, 0));
    ab = $urandom;
    mon_clear();
    cmd_index = ia;
    cmd_arg = aa;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_index = ib;
    cmd_arg = ab;
    k = 0;
    while (done_cnt < 1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("b2b", 2);
    chk("b2b_frame_a", 64'(get_frame(0)), 64'(frame_ref(ia, aa)));
    chk("b2b_frame_b", 64'(get_frame(NB)), 64'(frame_ref(ib, ab)));
    chk("b2b_done_cnt", 64'(done_cnt), 64'd2);
    chk("b2b_gap",
        64'((start_cyc.size() > 1 && done_cyc.size() > 0) ?
            start_cyc[1] - done_cyc[0] : -1),
        64'd2);
    chk("b2b_busy", 64'(hs_bad), 64'd0);

    ce_mode = 0;
    mon_clear();
    handshake(6'($urandom_range(63, 0)), $urandom);
    k = 0;
    while (q_bits.size() < 24 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_oe", 64'(cmd_oe), 64'd0);
    chk("mid_rst_o", 64'(cmd_o), 64'd1);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
    run_frame("post_rst", 6'd0, 32'h0, 48'h40_00_00_00_00_95);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
